seg_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the board's 4-digit common-anode seven-segment display.
- Rotates the active-low anode select through the four digits at a programmable rate.
- Picks the matching nibble of a 16-bit display word and decodes it to active-low segments.
- Takes new display values through a load strobe and applies them only at frame boundaries, so the display never tears.

---
 rtl/seg_scan_ctrl.sv | 120 ++++++++++++
 tb/tb_seg_scan_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode seven-segment scanner with frame-synchronous value
// commit, leading-zero blanking and per-digit decimal points.

module seg_digit (
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb begin
    seg = 7'h7F;
    if (!blank) begin
      unique case (nib)
        4'h0: seg = 7'b1000000;
        4'h1: seg = 7'b1111001;
        4'h2: seg = 7'b0100100;
        4'h3: seg = 7'b0110000;
        4'h4: seg = 7'b0011001;
        4'h5: seg = 7'b0010010;
        4'h6: seg = 7'b0000010;
        4'h7: seg = 7'b1111000;
        4'h8: seg = 7'b0000000;
        4'h9: seg = 7'b0010000;
        4'hA: seg = 7'b0001000;
        4'hB: seg = 7'b0000011;
        4'hC: seg = 7'b1000110;
        4'hD: seg = 7'b0100001;
        4'hE: seg = 7'b0000110;
        4'hF: seg = 7'b0001110;
      endcase
    end
  end
endmodule

module seg_scan_ctrl #(
  parameter int DIV_COUNT = 100000,
  parameter int CNT_W     = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        enable,
  input  logic        blank_lz,
  input  logic [3:0]  dp,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic        frame_tick,
  output logic        pending
);
  localparam int NUM_DIG = 4;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV_COUNT - 1);

  logic [CNT_W-1:0]              cnt;
  logic [1:0]                    idx;
  logic [15:0]                   disp, shadow;
  logic [NUM_DIG-1:0][3:0]       nib;
  logic [NUM_DIG-1:0]            blank;
  logic [NUM_DIG-1:0][6:0]       dig_seg;
  logic                          slot_end, wrap, commit;

  assign nib      = disp;
  assign slot_end = enable && (cnt == LAST);
  assign wrap     = slot_end && (idx == 2'd3);
  // Dark display has no frame to tear, so commits happen immediately.
  assign commit   = wrap || !enable;

  // Digit k blanks only when it and every digit to its left are zero.
  for (genvar k = 0; k < NUM_DIG; k++) begin : g_dig
    if (k == 0) begin : g_lsd
      assign blank[k] = 1'b0;
    end else begin : g_hi
      assign blank[k] = blank_lz && ~|disp[15:4*k];
    end
    seg_digit u_dig (.nib(nib[k]), .blank(blank[k]), .seg(dig_seg[k]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      disp       <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      frame_tick <= 1'b0;
      an         <= 4'hF;
      seg        <= 7'h7F;
      dp_n       <= 1'b1;
    end else begin
      if (enable) begin
        if (slot_end) begin
          cnt <= '0;
          idx <= idx + 2'd1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
      frame_tick <= wrap;

      if (commit) begin
        if (load)         disp <= value;
        else if (pending) disp <= shadow;
        pending <= 1'b0;
      end else if (load) begin
        shadow  <= value;
        pending <= 1'b1;
      end

      if (enable) begin
        an   <= ~(4'b0001 << idx);
        seg  <= dig_seg[idx];
        dp_n <= ~dp[idx];
      end else begin
        an   <= 4'hF;
        seg  <= 7'h7F;
        dp_n <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a time-based reference model checked every cycle,
// plus directed literal checks at hand-computed points.

module tb_seg_scan_ctrl;
  localparam int D     = 4;
  localparam int FRAME = 4 * D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] value = '0;
  logic        load = 1'b0, enable = 1'b1, blank_lz = 1'b0;
  logic [3:0]  dp = 4'b0100;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_n, frame_tick, pending;

  int tests = 0, fails = 0;

  seg_scan_ctrl #(.DIV_COUNT(D), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .value(value), .load(load), .enable(enable),
    .blank_lz(blank_lz), .dp(dp), .an(an), .seg(seg), .dp_n(dp_n),
    .frame_tick(frame_tick), .pending(pending)
  );

  always #5 clk = ~clk;

  logic [6:0] segtab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  // Model: position in the scan is just the count of enabled clock edges.
  int          ticks = 0;
  logic [15:0] mdisp = '0, msh = '0;
  logic        mpend = 1'b0;
  logic [3:0]  e_an = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dpn = 1'b1, e_ft = 1'b0, e_pend = 1'b0;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      ticks = 0; mdisp = '0; msh = '0; mpend = 1'b0;
      e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1; e_ft = 1'b0; e_pend = 1'b0;
    end else begin
      int k;
      logic bnd;
      k = (ticks / D) % 4;
      if (enable) begin
        e_an  = ~(4'b0001 << k);
        e_seg = (blank_lz && k > 0 && (mdisp >> (4 * k)) == 0) ? 7'h7F
                : segtab[(mdisp >> (4 * k)) & 16'hF];
        e_dpn = ~dp[k];
      end else begin
        e_an = 4'hF; e_seg = 7'h7F; e_dpn = 1'b1;
      end
      bnd  = enable && (ticks % FRAME == FRAME - 1);
      e_ft = bnd;
      if (!enable || bnd) begin
        if (load) mdisp = value;
        else if (mpend) mdisp = msh;
        mpend = 1'b0;
      end else if (load) begin
        msh = value; mpend = 1'b1;
      end
      if (enable) ticks++;
      e_pend = mpend;
    end
  end

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    chk("an", 16'(an), 16'(e_an));
    chk("seg", 16'(seg), 16'(e_seg));
    chk("dp_n", 16'(dp_n), 16'(e_dpn));
    chk("frame_tick", 16'(frame_tick), 16'(e_ft));
    chk("pending", 16'(pending), 16'(e_pend));
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance until the model's scan position mod FRAME equals r.
  task automatic to_tick(input int r);
    int guard = 0;
    while (ticks % FRAME != r && guard < 64) begin
      step();
      guard++;
    end
    if (guard >= 64) begin
      tests++; fails++;
      $display("FAIL to_tick: position %0d never reached", r);
    end
  endtask

  initial begin
    step(3);
    chk("reset_an", 16'(an), 16'hF);
    chk("reset_seg", 16'(seg), 16'h7F);

    // Load 1234 right after reset; commits at the first wrap.
    rst = 1'b0; load = 1'b1; value = 16'h1234;
    step(); load = 1'b0;
    chk("lit_pend_first", 16'(pending), 16'd1);
    chk("lit_an_first", 16'(an), 16'hE);
    step(15);
    chk("lit_ft_wrap", 16'(frame_tick), 16'd1);
    chk("lit_pend_wrap", 16'(pending), 16'd0);
    step();
    chk("lit_an_d0", 16'(an), 16'hE);
    chk("lit_seg_4", 16'(seg), 16'(7'b0011001));
    step(4);
    chk("lit_an_d1", 16'(an), 16'hD);
    chk("lit_seg_3", 16'(seg), 16'(7'b0110000));

    // Mid-frame load at idx 1.
    load = 1'b1; value = 16'hABCD; step(); load = 1'b0;
    chk("lit_pend_mid", 16'(pending), 16'd1);
    step(14);

    // Two loads in one frame; last wins.
    to_tick(2);
    load = 1'b1; value = 16'h1111; step(); load = 1'b0;
    step(3);
    load = 1'b1; value = 16'h2222; step(); load = 1'b0;
    step(20);

    // Load on the boundary cycle, with leading-zero blanking.
    blank_lz = 1'b1;
    to_tick(15);
    load = 1'b1; value = 16'h0070; step(); load = 1'b0;
    chk("lit_pend_bnd", 16'(pending), 16'd0);
    step(7);
    chk("lit_an_7", 16'(an), 16'hD);
    chk("lit_seg_7", 16'(seg), 16'(7'b1111000));
    step(4);
    chk("lit_seg_blank", 16'(seg), 16'h7F);
    load = 1'b1; value = 16'h0000; step(); load = 1'b0;
    step(24);

    // Disable mid-scan at idx 2; load commits immediately.
    to_tick(9);
    enable = 1'b0; step();
    chk("lit_an_dark", 16'(an), 16'hF);
    load = 1'b1; value = 16'h5555; step(); load = 1'b0;
    step();
    chk("lit_pend_dis", 16'(pending), 16'd0);
    enable = 1'b1; step();
    chk("lit_an_resume", 16'(an), 16'hB);
    chk("lit_seg_5", 16'(seg), 16'(7'b0010010));
    step(10);

    // Async reset while idx 3 with a value pending.
    to_tick(13);
    load = 1'b1; value = 16'h9999; step(); load = 1'b0;
    chk("lit_pend_pre_rst", 16'(pending), 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("lit_rst_an", 16'(an), 16'hF);
    chk("lit_rst_seg", 16'(seg), 16'h7F);
    chk("lit_rst_pend", 16'(pending), 16'd0);
    step(2);
    rst = 1'b0;
    step(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
